// File: rtl/tb_common_pkg.sv
// Shared definitions for the bench-side scoreboard blocks.
//   clog2            : ceiling log2 helper for sizing pointers and indices
//   sb_status_e      : run/pass/fail status encoding; bit 1 = pass, bit 0 = fail
//   DEFAULT_CNT_WIDTH: default width of scoreboard counters
package tb_common_pkg;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SB_RUN  = 2'b00,
    SB_FAIL = 2'b01,
    SB_PASS = 2'b10
  } sb_status_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/scoreboard_fifo.sv
// Synchronous FIFO holding expected values for the stream scoreboard.
//   clk, reset : clock and synchronous active-high reset (empties FIFO)
//   push       : write push_data when not full
//   push_data  : value to enqueue
//   pop        : discard head entry when not empty
//   head       : current oldest entry
//   full/empty : registered occupancy flags
module scoreboard_fifo
  import tb_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           wr_ptr_next;
  logic [AW:0]           rd_ptr_next;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr + {{AW{1'b0}}, do_push};
    rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  // Flags are computed from next-state pointers so they come straight out of flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      mem    <= '{default: '0};
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty  <= (wr_ptr_next == rd_ptr_next);
    end
  end

endmodule

// File: rtl/stream_scoreboard.sv
// In-order stream scoreboard: buffers expected values, compares them against
// the DUT output stream and raises sticky pass/fail.
//   clk, reset          : clock, synchronous active-high reset
//   exp_data/valid/ready: expected-value stream (stimulus side)
//   act_data/valid/ready: DUT output stream
//   pass, fail          : sticky, mutually exclusive result flags
//   match_count         : matching compares
//   error_count         : mismatching compares (saturating)
//   first_err_index     : 0-based beat index of first mismatch
module stream_scoreboard
  import tb_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned NUM_EXPECTED = 64,
  parameter int unsigned MAX_ERRORS   = 1,
  parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic                  pass,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  first_err_index
);

  localparam logic [CNT_WIDTH-1:0] MAX_ERR_C = CNT_WIDTH'(MAX_ERRORS);
  localparam logic [CNT_WIDTH:0]   NUM_EXP_C = (CNT_WIDTH + 1)'(NUM_EXPECTED);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

  sb_status_e            status;
  logic                  done;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;

  logic                  cmp_valid;
  logic                  cmp_match;
  logic [CNT_WIDTH-1:0]  cmp_index;
  logic [CNT_WIDTH-1:0]  beat_index;

  logic                  upd;
  logic [CNT_WIDTH-1:0]  match_next;
  logic [CNT_WIDTH-1:0]  error_next;
  logic [CNT_WIDTH:0]    total_next;
  logic                  hit_fail;
  logic                  hit_pass;

  assign done      = (status != SB_RUN);
  assign pass      = (status == SB_PASS);
  assign fail      = (status == SB_FAIL);
  assign exp_ready = !full && !done;
  assign act_ready = !empty && !done;
  assign push      = exp_valid && exp_ready;
  assign pop       = act_valid && act_ready;

  scoreboard_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (exp_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // A compare still in flight when done rises is dropped so the result stays frozen.
  always_comb begin
    upd        = cmp_valid && !done;
    match_next = match_count;
    error_next = error_count;
    if (upd) begin
      if (cmp_match) match_next = match_count + ONE_C;
      else if (error_count != '1) error_next = error_count + ONE_C;
    end
    total_next = {1'b0, match_next} + {1'b0, error_next};
    hit_fail   = upd && (error_next >= MAX_ERR_C);
    hit_pass   = upd && (total_next >= NUM_EXP_C) && (error_next < MAX_ERR_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status          <= SB_RUN;
      cmp_valid       <= 1'b0;
      cmp_match       <= 1'b0;
      cmp_index       <= '0;
      beat_index      <= '0;
      match_count     <= '0;
      error_count     <= '0;
      first_err_index <= '0;
    end else begin
      cmp_valid <= pop;
      if (pop) begin
        cmp_match  <= (act_data === head);
        cmp_index  <= beat_index;
        beat_index <= beat_index + ONE_C;
      end
      match_count <= match_next;
      error_count <= error_next;
      if (upd && !cmp_match && (error_count == '0)) first_err_index <= cmp_index;
      if (hit_fail)      status <= SB_FAIL;
      else if (hit_pass) status <= SB_PASS;
    end
  end

endmodule

// File: tb/tb_stream_scoreboard.sv
// Directed bench for stream_scoreboard. Two instances: A (MAX_ERRORS=1) and
// B (MAX_ERRORS=3), both NUM_EXPECTED=8, FIFO_DEPTH=16. A reference queue
// mirrors the expected stream and a small model predicts counters/flags.
module tb_stream_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] exp_data;
  logic [15:0] act_data;
  logic        exp_valid;
  logic        act_valid;
  logic        sel;

  logic        a_exp_valid, a_act_valid, a_exp_ready, a_act_ready, a_pass, a_fail;
  logic [15:0] a_match, a_err, a_first;
  logic        b_exp_valid, b_act_valid, b_exp_ready, b_act_ready, b_pass, b_fail;
  logic [15:0] b_match, b_err, b_first;

  assign a_exp_valid = exp_valid && !sel;
  assign a_act_valid = act_valid && !sel;
  assign b_exp_valid = exp_valid && sel;
  assign b_act_valid = act_valid && sel;

  stream_scoreboard #(
    .DATA_WIDTH(16), .FIFO_DEPTH(16), .NUM_EXPECTED(8), .MAX_ERRORS(1), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .exp_data(exp_data), .exp_valid(a_exp_valid), .exp_ready(a_exp_ready),
    .act_data(act_data), .act_valid(a_act_valid), .act_ready(a_act_ready),
    .pass(a_pass), .fail(a_fail),
    .match_count(a_match), .error_count(a_err), .first_err_index(a_first)
  );

  stream_scoreboard #(
    .DATA_WIDTH(16), .FIFO_DEPTH(16), .NUM_EXPECTED(8), .MAX_ERRORS(3), .CNT_WIDTH(16)
  ) dut_b (
    .clk(clk), .reset(reset),
    .exp_data(exp_data), .exp_valid(b_exp_valid), .exp_ready(b_exp_ready),
    .act_data(act_data), .act_valid(b_act_valid), .act_ready(b_act_ready),
    .pass(b_pass), .fail(b_fail),
    .match_count(b_match), .error_count(b_err), .first_err_index(b_first)
  );

  logic        exp_ready, act_ready, pass, fail;
  logic [15:0] match_count, error_count, first_err_index;
  assign exp_ready       = sel ? b_exp_ready : a_exp_ready;
  assign act_ready       = sel ? b_act_ready : a_act_ready;
  assign pass            = sel ? b_pass      : a_pass;
  assign fail            = sel ? b_fail      : a_fail;
  assign match_count     = sel ? b_match     : a_match;
  assign error_count     = sel ? b_err       : a_err;
  assign first_err_index = sel ? b_first     : a_first;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [15:0] exp_q[$];
  int unsigned m_match, m_err, m_first, m_idx, m_maxerr;
  bit          m_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  task automatic chk_bound(input string tag, input bit ok);
    n_total++;
    assert (ok) n_pass++;
    else $error("FAIL %s: handshake observed never, required within bound", tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_match  = 0;
    m_err    = 0;
    m_first  = 0;
    m_idx    = 0;
    m_done   = 0;
    m_maxerr = sel ? 3 : 1;
  endtask

  task automatic model_compare(input logic [15:0] v);
    logic [15:0] h;
    h = exp_q.pop_front();
    if (!m_done) begin
      if (v !== h) begin
        if (m_err == 0) m_first = m_idx;
        m_err++;
      end else begin
        m_match++;
      end
      if (m_err >= m_maxerr || (m_match + m_err) >= 8) m_done = 1;
    end
    m_idx++;
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    act_valid = 1'b0;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    model_reset();
  endtask

  task automatic push_exp(input logic [15:0] v);
    bit ok, rdy;
    ok        = 0;
    exp_data  = v;
    exp_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = exp_ready;
      step();
      if (rdy) ok = 1;
    end
    exp_valid = 1'b0;
    if (ok) exp_q.push_back(v);
    chk_bound("exp_push", ok);
  endtask

  task automatic send_act(input logic [15:0] v);
    bit ok, rdy;
    ok        = 0;
    act_data  = v;
    act_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = act_ready;
      step();
      if (rdy) ok = 1;
    end
    act_valid = 1'b0;
    if (ok) model_compare(v);
    chk_bound("act_send", ok);
  endtask

  task automatic chk_model(input string tag);
    bit mf, mp;
    mf = (m_err >= m_maxerr);
    mp = !mf && ((m_match + m_err) >= 8);
    chk({tag, ".match"}, 32'(match_count), 32'(m_match));
    chk({tag, ".err"},   32'(error_count), 32'(m_err));
    chk({tag, ".pass"},  32'(pass),        32'(mp));
    chk({tag, ".fail"},  32'(fail),        32'(mf));
    if (m_err > 0) chk({tag, ".first"}, 32'(first_err_index), 32'(m_first));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel       = 1'b0;
    reset     = 1'b0;
    exp_data  = '0;
    act_data  = '0;
    exp_valid = 1'b0;
    act_valid = 1'b0;
    step();

    // Reset state and clean 8-beat pass on A
    do_reset();
    chk("rst.exp_ready", 32'(exp_ready), 32'd1);
    chk("rst.act_ready", 32'(act_ready), 32'd0);
    chk_model("rst");
    for (int i = 0; i < 8; i++) push_exp(16'(i));
    for (int i = 0; i < 8; i++) send_act(16'(i));
    chk("t1.pass_early", 32'(pass), 32'd0);
    step();
    chk_model("t1");
    chk("t1.pass", 32'(pass), 32'd1);

    // Single mismatch at beat 3 with MAX_ERRORS=1
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(16'(i));
    for (int i = 0; i < 3; i++) send_act(16'(i));
    send_act(16'hDEAD);
    chk("t2.fail_early", 32'(fail), 32'd0);
    step();
    chk_model("t2");
    chk("t2.fail", 32'(fail), 32'd1);
    chk("t2.first", 32'(first_err_index), 32'd3);
    step();
    chk("t2.act_ready", 32'(act_ready), 32'd0);
    chk("t2.exp_ready", 32'(exp_ready), 32'd0);
    act_data  = 16'h0004;
    act_valid = 1'b1;
    exp_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    act_valid = 1'b0;
    exp_valid = 1'b0;
    chk_model("t2.frozen");

    // Three mismatches (beats 1, 4, 6) on B with MAX_ERRORS=3
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(16'(i));
    for (int i = 0; i < 7; i++) begin
      if (i == 1 || i == 4 || i == 6) send_act(16'(i) ^ 16'h8000);
      else send_act(16'(i));
      if (i == 4) begin
        step();
        step();
        chk_model("t3.mid");
      end
    end
    step();
    chk_model("t3");
    chk("t3.fail", 32'(fail), 32'd1);
    chk("t3.match", 32'(match_count), 32'd4);
    chk("t3.first", 32'(first_err_index), 32'd1);
    sel = 1'b0;

    // FIFO full boundary: 16 pushes, one pop reopens, 17th push accepted
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(16'(16'h100 + i));
    chk("t4.full", 32'(exp_ready), 32'd0);
    send_act(16'h0100);
    chk("t4.reopen", 32'(exp_ready), 32'd1);
    push_exp(16'h0110);
    chk("t4.full_again", 32'(exp_ready), 32'd0);
    step();
    chk_model("t4");

    // act_valid held against an empty FIFO
    do_reset();
    act_data  = 16'h0055;
    act_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5.act_ready_empty", 32'(act_ready), 32'd0);
    end
    chk_model("t5.idle");
    push_exp(16'h0055);
    act_valid = 1'b1;
    chk("t5.act_ready_next", 32'(act_ready), 32'd1);
    send_act(16'h0055);
    step();
    chk_model("t5");
    chk("t5.match", 32'(match_count), 32'd1);

    // Mid-run reset with 3 values queued, then a fresh pass
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(16'(i));
    for (int i = 0; i < 5; i++) send_act(16'(i));
    step();
    step();
    chk_model("t6.pre");
    do_reset();
    chk("t6.exp_ready", 32'(exp_ready), 32'd1);
    chk("t6.act_ready", 32'(act_ready), 32'd0);
    chk_model("t6.post");
    for (int i = 0; i < 8; i++) push_exp(16'(16'h0A0 + i));
    for (int i = 0; i < 8; i++) send_act(16'(16'h0A0 + i));
    step();
    chk_model("t6.rerun");
    chk("t6.pass", 32'(pass), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_scoreboard.md
Name: stream_scoreboard

Overview:
- Self-checking scoreboard that produces the `pass`/`fail` pair consumed by the testbench status/finish block. It sits directly upstream of that block.
- It buffers an expected-value stream from the stimulus side and compares it, in order, against the DUT output stream.
- It asserts a sticky `pass` once NUM_EXPECTED beats match. It asserts a sticky `fail` once MAX_ERRORS mismatches are seen.
- Intended for simulation benches in the accelerator verification tree; written in synthesizable style so it can also run in emulation.

Parameters:
- DATA_WIDTH, 16, width of expected and actual data.
- FIFO_DEPTH, 16, expected-value buffer depth; must be a power of two, at least 2.
- NUM_EXPECTED, 64, number of compared beats required for pass; at least 1.
- MAX_ERRORS, 1, mismatch count that triggers fail; at least 1.
- CNT_WIDTH, 16, width of the counters and the index output.

Ports:
- clk  input  1  bench clock.
- reset  input  1  synchronous, active-high reset.
- exp_data  input  DATA_WIDTH  expected value from the stimulus/model.
- exp_valid  input  1  expected value valid.
- exp_ready  output  1  scoreboard can accept an expected value.
- act_data  input  DATA_WIDTH  DUT output value.
- act_valid  input  1  DUT output valid.
- act_ready  output  1  scoreboard can consume a DUT output.
- pass  output  1  sticky; all NUM_EXPECTED beats compared with fewer than MAX_ERRORS mismatches.
- fail  output  1  sticky; MAX_ERRORS mismatches reached.
- match_count  output  CNT_WIDTH  number of matching compares.
- error_count  output  CNT_WIDTH  number of mismatching compares; saturates at all-ones.
- first_err_index  output  CNT_WIDTH  beat index (0-based) of the first mismatch; meaningful only while error_count > 0.

Behaviour:
- Reset (synchronous, active-high): on the clock edge with reset=1, the FIFO is emptied and every register is cleared.
  - pass=0, fail=0, match_count=0, error_count=0, first_err_index=0.
  - The compare stage is invalidated and the beat index is set to 0.
  - Reset asserted mid-run discards any in-flight compare; no counter update occurs from it.
- Handshakes:
  - A beat transfers on a cycle where valid and ready are both 1.
  - valid may be held; data must be stable while valid=1 and ready=0.
- done = pass | fail.
- exp_ready = !full && !done, decoded from registered state only.
  - No push-through when full: a pop in the same cycle does not raise exp_ready that cycle.
- act_ready = !empty && !done.
  - No bypass when the FIFO is empty: an expected push in cycle N allows an actual handshake no earlier than cycle N+1.
- Simultaneous push and pop with the FIFO neither empty nor full: both happen; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- Compare pipeline:
  - Actual handshake in cycle N: the FIFO head is popped.
  - At the end of cycle N, cmp_valid, cmp_match and cmp_index register.
    - cmp_match = (act_data === head), so X or Z on either side counts as a mismatch.
    - cmp_index = beat index, which then increments.
  - During cycle N+1 the counters update; the new values, pass and fail are visible in cycle N+2.
- Counter update on cmp_valid:
  - Match: match_count increments.
  - Mismatch: error_count increments (saturating). If error_count was 0, first_err_index is loaded with cmp_index.
- fail is set when the updated error_count reaches MAX_ERRORS.
- pass is set when the updated count of compared beats (match_count + error_count) reaches NUM_EXPECTED with error_count < MAX_ERRORS.
- If both conditions occur on the same compare, fail wins and pass stays 0.
- pass and fail are registered, sticky, and mutually exclusive; only reset clears them.
- After done, no further handshakes occur; the FIFO contents are frozen.
- Expected values left in the FIFO at pass are not an error.

Decomposition:
- Shared package: tb_common_pkg, holding clog2 helpers, the done/pass/fail encoding constants, and the default CNT_WIDTH.
- One sub-module: scoreboard_fifo, a synchronous FIFO with full/empty flags and registered outputs. The compare pipeline and counters stay in stream_scoreboard.

Test Plan:
- NUM_EXPECTED=8: push expected 0..7, send actual 0..7 back-to-back.
  - Required: pass=1 two cycles after the last actual handshake, fail=0, match_count=8, error_count=0.
- Actual beat 3 = 16'hDEAD against expected 16'h0003, MAX_ERRORS=1.
  - Required: fail=1 at handshake cycle +2, error_count=1, first_err_index=3.
  - Required: act_ready=0 and exp_ready=0 afterwards; pass never asserts.
- MAX_ERRORS=3, mismatches at beats 1, 4 and 6.
  - Required: fail asserts only after beat 6, error_count=3, first_err_index=1, match_count=4.
- FIFO_DEPTH=16: push 16 expected values with act_valid=0.
  - Required: exp_ready=0 in the cycle after the 16th push.
  - Then one actual handshake: exp_ready=1 the following cycle, and a 17th push is accepted.
- act_valid=1 held with the FIFO empty.
  - Required: act_ready=0 and counters unchanged.
  - Push one expected value in cycle N: act_ready=1 in cycle N+1, and the compare counts.
- Reset pulsed for 1 cycle after 5 matches with 3 values queued.
  - Required: all counters 0, exp_ready=1, act_ready=0, pass=fail=0.
  - A fresh 8-beat run then passes.
